fwd_sel_unit: RTL and testbench

//   Operand-forwarding controller for the EX stage of the pipelined datapath.

---
 rtl/fwd_pkg.sv | 39 +++
 rtl/fwd_stage_reg.sv | 26 ++
 rtl/fwd_sel_unit.sv | 92 +++++++++
 tb/tb_fwd_sel_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// mux select encodings, the per-stage destination tag bundle and the select decode.
package fwd_pkg;

  localparam int TAG_ADDR_W = 4;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  localparam logic [TAG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [TAG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  // The MEM stage holds the youngest in-flight result, so it is checked first.
  function automatic logic [1:0] fwd_select(
    input logic [TAG_ADDR_W-1:0] src,
    input logic [TAG_ADDR_W-1:0] mem_rd,
    input logic                  mem_wr_en,
    input logic [TAG_ADDR_W-1:0] wb_rd,
    input logic                  wb_wr_en
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (mem_wr_en && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = SEL_EXMEM;
    end else if (wb_wr_en && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = SEL_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline destination-tag register: async clear, hold has priority over
// bubble insertion, otherwise captures the upstream tag.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  stage_tag_t d,
  output stage_tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= TAG_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= TAG_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fwd_sel_unit.sv
// EX-stage operand forwarding controller: tracks EX/MEM/WB destination tags,
// drives the A/B operand mux selects and the load-use stall request to ID.
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = TAG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  load_stall
);

  stage_tag_t            id_tag;
  stage_tag_t            ex_tag;
  stage_tag_t            mem_tag;
  stage_tag_t            wb_tag;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  hold;
  logic                  ex_bubble;
  logic                  wb_unused;

  // Flush squashes EX even during a global stall; downstream still advances.
  assign hold      = stall && !flush;
  assign ex_bubble = flush || load_stall;

  assign id_tag = '{rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};

  fwd_stage_reg u_ex_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (ex_bubble),
    .d      (id_tag),
    .q      (ex_tag)
  );

  fwd_stage_reg u_mem_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (1'b0),
    .d      (ex_tag),
    .q      (mem_tag)
  );

  fwd_stage_reg u_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (1'b0),
    .d      (mem_tag),
    .q      (wb_tag)
  );

  // Load status is irrelevant once the result reaches WB.
  assign wb_unused = wb_tag.is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs <= '0;
      ex_rt <= '0;
    end else if (hold) begin
      ex_rs <= ex_rs;
      ex_rt <= ex_rt;
    end else if (ex_bubble) begin
      ex_rs <= '0;
      ex_rt <= '0;
    end else begin
      ex_rs <= id_rs;
      ex_rt <= id_rt;
    end
  end

  assign sel_a = fwd_select(ex_rs, mem_tag.rd, mem_tag.wr_en, wb_tag.rd, wb_tag.wr_en);
  assign sel_b = fwd_select(ex_rt, mem_tag.rd, mem_tag.wr_en, wb_tag.rd, wb_tag.wr_en);

  // A load result is only available from MEM/WB, so its consumer waits one cycle.
  assign load_stall = !flush && ex_tag.is_load && ex_tag.wr_en &&
                      (ex_tag.rd != REG_ZERO) &&
                      ((ex_tag.rd == id_rs) || (ex_tag.rd == id_rt));

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Bench for fwd_sel_unit: per-cycle instruction vectors with hand-derived
// expected selects, queued when driven and compared at the following negedge.
module tb_fwd_sel_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flush;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_wr_en, id_is_load;
  logic [1:0] sel_a, sel_b;
  logic       load_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_sel_unit #(.REG_ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .load_stall (load_stall)
  );

  typedef struct {
    string      name;
    logic       stall, flush;
    logic [3:0] rs, rt, rd;
    logic       wr, ld;
    logic [1:0] ea, eb;
    logic       els;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] a, b;
    logic       ls;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Bench-side view of EX/MEM source and destination tags, used only to
  // confirm the stimulus never puts a matched load in MEM.
  logic [3:0] sh_ex_rs = '0, sh_ex_rt = '0, sh_ex_rd = '0;
  logic       sh_ex_wr = 1'b0, sh_ex_ld = 1'b0;
  logic [3:0] sh_mem_rd = '0;
  logic       sh_mem_wr = 1'b0, sh_mem_ld = 1'b0;

  function automatic vec_t mk(string n, logic s, logic f, logic [3:0] rs, logic [3:0] rt,
                              logic [3:0] rd, logic wr, logic ld, logic [1:0] ea,
                              logic [1:0] eb, logic els);
    vec_t v;
    v.name = n; v.stall = s; v.flush = f; v.rs = rs; v.rt = rt; v.rd = rd;
    v.wr = wr; v.ld = ld; v.ea = ea; v.eb = eb; v.els = els;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    stall = v.stall; flush = v.flush;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_wr_en = v.wr; id_is_load = v.ld;
    e.name = v.name; e.a = v.ea; e.b = v.eb; e.ls = v.els;
    sb.push_back(e);
  endtask

  task automatic push_exp(input string n, input logic [1:0] a, input logic [1:0] b, input logic ls);
    exp_t e;
    e.name = n; e.a = a; e.b = b; e.ls = ls;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: no expected record queued");
    end else begin
      e = sb.pop_front();
      tests++;
      if (sel_a !== e.a) begin
        fails++;
        $display("FAIL %s sel_a: got %b expected %b", e.name, sel_a, e.a);
      end
      tests++;
      if (sel_b !== e.b) begin
        fails++;
        $display("FAIL %s sel_b: got %b expected %b", e.name, sel_b, e.b);
      end
      tests++;
      if (load_stall !== e.ls) begin
        fails++;
        $display("FAIL %s load_stall: got %b expected %b", e.name, load_stall, e.ls);
      end
    end
  endtask

  task automatic shadow_step(input vec_t v);
    if (sh_mem_ld && sh_mem_wr && sh_mem_rd != 4'd0 &&
        (sh_mem_rd == sh_ex_rs || sh_mem_rd == sh_ex_rt)) begin
      fails++;
      $display("FAIL %s stim_load_in_mem: MEM load r%0d used by EX", v.name, sh_mem_rd);
    end
    if (v.flush || (!v.stall && v.els)) begin
      sh_mem_rd = sh_ex_rd; sh_mem_wr = sh_ex_wr; sh_mem_ld = sh_ex_ld;
      sh_ex_rs = '0; sh_ex_rt = '0; sh_ex_rd = '0; sh_ex_wr = 1'b0; sh_ex_ld = 1'b0;
    end else if (!v.stall) begin
      sh_mem_rd = sh_ex_rd; sh_mem_wr = sh_ex_wr; sh_mem_ld = sh_ex_ld;
      sh_ex_rs = v.rs; sh_ex_rt = v.rt; sh_ex_rd = v.rd; sh_ex_wr = v.wr; sh_ex_ld = v.ld;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_wr_en = 1'b0; id_is_load = 1'b0;

    //          name            st fl rs     rt     rd     wr ld ea     eb     ls
    vecs.push_back(mk("add_r3",      0, 0, 4'd1,  4'd2,  4'd3,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("add_r4_r3",   0, 0, 4'd3,  4'd1,  4'd4,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("exmem_fwd",   0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b01, 2'b00, 0));
    vecs.push_back(mk("wr_r5_a",     0, 0, 4'd0,  4'd0,  4'd5,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("wr_r5_b",     0, 0, 4'd0,  4'd0,  4'd5,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("rd_r5",       0, 0, 4'd5,  4'd5,  4'd6,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("youngest",    0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b01, 2'b01, 0));
    vecs.push_back(mk("wr_r8",       0, 0, 4'd0,  4'd0,  4'd8,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("gap_nop",     0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("rd_r8",       0, 0, 4'd1,  4'd8,  4'd9,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("memwb_fwd",   0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk("wr_r0",       0, 0, 4'd1,  4'd1,  4'd0,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("rd_r0",       0, 0, 4'd0,  4'd0,  4'd10, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("r0_in_mem",   0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("r0_in_wb",    0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("ld_r2",       0, 0, 4'd1,  4'd0,  4'd2,  1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(mk("use_r2",      0, 0, 4'd1,  4'd2,  4'd11, 1, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk("use_r2_rpt",  0, 0, 4'd1,  4'd2,  4'd11, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("load_fwd",    0, 0, 4'd0,  4'd0,  4'd13, 1, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk("rd_r13_r11",  0, 0, 4'd13, 4'd11, 4'd14, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("stall_1",     1, 0, 4'd5,  4'd6,  4'd7,  1, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk("stall_2",     1, 0, 4'd5,  4'd6,  4'd7,  1, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk("stall_3",     1, 0, 4'd5,  4'd6,  4'd7,  1, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk("stall_flush", 1, 1, 4'd5,  4'd6,  4'd7,  1, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk("post_flush",  0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("ld_r4",       0, 0, 4'd0,  4'd0,  4'd4,  1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(mk("flush_gate",  0, 1, 4'd4,  4'd0,  4'd5,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("after_gate",  0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("ld_r0",       0, 0, 4'd0,  4'd0,  4'd0,  1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(mk("use_r0",      0, 0, 4'd0,  4'd0,  4'd1,  1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk("tail_nop",    0, 0, 4'd0,  4'd0,  4'd0,  0, 0, 2'b00, 2'b00, 0));

    #3;
    push_exp("in_reset", 2'b00, 2'b00, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check_out();
      shadow_step(vecs[i]);
    end

    // Live forwarding and a pending load-use, then an async reset mid-cycle.
    @(posedge clk); #1;
    drive(mk("pre_add_r3", 0, 0, 4'd0, 4'd0, 4'd3, 1, 0, 2'b00, 2'b00, 0));
    @(negedge clk); check_out();
    @(posedge clk); #1;
    drive(mk("pre_ld_r6", 0, 0, 4'd3, 4'd3, 4'd6, 1, 1, 2'b00, 2'b00, 0));
    @(negedge clk); check_out();
    @(posedge clk); #1;
    drive(mk("pre_use_r6", 0, 0, 4'd6, 4'd0, 4'd0, 0, 0, 2'b01, 2'b01, 1));
    @(negedge clk); check_out();
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 2'b00, 2'b00, 1'b0);
    check_out();
    @(posedge clk); #1;
    push_exp("reset_held", 2'b00, 2'b00, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(mk("post_reset", 0, 0, 4'd6, 4'd0, 4'd0, 0, 0, 2'b00, 2'b00, 0));
    @(negedge clk); check_out();

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: %0d records remain, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
